// File: rtl/sw_allocator.sv
// Switch allocator for one NoC router: per-output round-robin arbitration with
// packet locking from head to tail flit, registered grants and crossbar controls.
module sw_allocator #(
  parameter int NUM_PORTS = 4,
  parameter int SEL_W     = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_PORTS-1:0]         sw_req_valid,
  input  logic [NUM_PORTS*NUM_PORTS-1:0] sw_req,
  input  logic [NUM_PORTS-1:0]         sw_req_tail,
  input  logic [NUM_PORTS-1:0]         out_ready,
  output logic [NUM_PORTS-1:0]         sw_grant,
  output logic [NUM_PORTS*SEL_W-1:0]   xbar_sel,
  output logic [NUM_PORTS-1:0]         xbar_valid,
  output logic                         req_err
);

  function automatic logic is_onehot(input logic [NUM_PORTS-1:0] v);
    return (v != '0) && ((v & (v - NUM_PORTS'(1))) == '0);
  endfunction

  logic [NUM_PORTS-1:0] locked;
  logic [SEL_W-1:0]     owner [NUM_PORTS];
  logic [SEL_W-1:0]     ptr   [NUM_PORTS];

  logic [NUM_PORTS-1:0] eligible;
  logic [NUM_PORTS-1:0] win_valid;
  logic [SEL_W-1:0]     win_idx [NUM_PORTS];
  logic [NUM_PORTS-1:0] grant_next;
  logic                 err_next;

  // Request decode and per-output winner selection (locked owner or round-robin)
  always_comb begin
    logic [NUM_PORTS-1:0] slice;
    logic                 ok;
    logic                 found;
    logic                 hit;
    int                   idx;
    eligible   = '0;
    win_valid  = '0;
    grant_next = '0;
    err_next   = 1'b0;
    slice      = '0;
    ok         = 1'b0;
    found      = 1'b0;
    hit        = 1'b0;
    idx        = 0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      slice       = sw_req[i*NUM_PORTS +: NUM_PORTS];
      ok          = is_onehot(slice);
      eligible[i] = sw_req_valid[i] & ok & ~sw_grant[i];
      err_next    = err_next | (sw_req_valid[i] & ~ok);
    end
    for (int o = 0; o < NUM_PORTS; o++) begin
      win_idx[o] = owner[o];
      found      = 1'b0;
      if (locked[o]) begin
        found = out_ready[o] && eligible[owner[o]] &&
                sw_req[int'(owner[o])*NUM_PORTS + o];
      end else begin
        for (int k = 0; k < NUM_PORTS; k++) begin
          idx = int'(ptr[o]) + k;
          if (idx >= NUM_PORTS) begin
            idx = idx - NUM_PORTS;
          end else begin
            idx = idx;
          end
          hit = out_ready[o] && !found && eligible[idx] && sw_req[idx*NUM_PORTS + o];
          if (hit) begin
            found      = 1'b1;
            win_idx[o] = SEL_W'(idx);
          end else begin
            found = found;
          end
        end
      end
      win_valid[o] = found;
    end
    for (int o = 0; o < NUM_PORTS; o++) begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        grant_next[i] = grant_next[i] | (win_valid[o] && (win_idx[o] == SEL_W'(i)));
      end
    end
  end

  // Output registers, lock state and round-robin pointers
  always_ff @(posedge clk) begin
    if (rst) begin
      sw_grant   <= '0;
      xbar_valid <= '0;
      xbar_sel   <= '0;
      req_err    <= 1'b0;
      locked     <= '0;
      for (int o = 0; o < NUM_PORTS; o++) begin
        owner[o] <= '0;
        ptr[o]   <= '0;
      end
    end else begin
      sw_grant   <= grant_next;
      xbar_valid <= win_valid;
      req_err    <= err_next;
      for (int o = 0; o < NUM_PORTS; o++) begin
        if (win_valid[o]) begin
          xbar_sel[o*SEL_W +: SEL_W] <= win_idx[o];
          if (locked[o]) begin
            locked[o] <= ~sw_req_tail[win_idx[o]];
          end else begin
            // Pointer only advances on head (or single-flit) wins
            ptr[o]    <= (win_idx[o] == SEL_W'(NUM_PORTS-1)) ? '0 : win_idx[o] + SEL_W'(1);
            locked[o] <= ~sw_req_tail[win_idx[o]];
            owner[o]  <= win_idx[o];
          end
        end else begin
          locked[o] <= locked[o];
        end
      end
    end
  end

endmodule

// File: tb/tb_sw_allocator.sv
// Self-checking bench for sw_allocator: directed scenarios plus random traffic
// checked cycle by cycle against a behavioural arbitration model.
module tb_sw_allocator;

  logic        clk = 1'b0;
  logic        rst_d;
  logic [3:0]  v_d, tl_d, rdy_d;
  logic [15:0] rq_d;
  logic [3:0]  sw_grant, xbar_valid;
  logic [7:0]  xbar_sel;
  logic        req_err;

  sw_allocator #(.NUM_PORTS(4), .SEL_W(2)) dut (
    .clk(clk), .rst(rst_d), .sw_req_valid(v_d), .sw_req(rq_d), .sw_req_tail(tl_d),
    .out_ready(rdy_d), .sw_grant(sw_grant), .xbar_sel(xbar_sel),
    .xbar_valid(xbar_valid), .req_err(req_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int pass_cnt = 0;
  int fail_cnt = 0;

  typedef struct packed { logic [3:0] slice; logic tail; logic bad; } flit_t;
  flit_t fbuf [4][256];
  int    fh [4];
  int    ft [4];

  // Reference model state
  logic       m_locked [4];
  int         m_owner  [4];
  int         m_ptr    [4];
  int         m_sel    [4];
  logic [3:0] m_grant;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int i, input logic [3:0] slice, input logic tail, input logic bad);
    fbuf[i][ft[i] % 256] = '{slice: slice, tail: tail, bad: bad};
    ft[i]++;
  endtask

  task automatic push_pkt(input int i, input int dst, input int len);
    for (int k = 0; k < len; k++) push(i, 4'(1 << dst), (k == len - 1), 1'b0);
  endtask

  task automatic drive();
    for (int i = 0; i < 4; i++) begin
      if (fh[i] != ft[i]) begin
        v_d[i]         = 1'b1;
        rq_d[i*4 +: 4] = fbuf[i][fh[i] % 256].slice;
        tl_d[i]        = fbuf[i][fh[i] % 256].tail;
      end else begin
        v_d[i]         = 1'b0;
        rq_d[i*4 +: 4] = 4'b0000;
        tl_d[i]        = 1'b0;
      end
    end
  endtask

  // One clock: predict from the model, advance the clock, compare, retire flits
  task automatic step();
    logic [3:0] eg, ev, elig;
    logic [7:0] es;
    logic       ee;
    int         dst [4];
    int         win;
    eg = 4'b0; ev = 4'b0; ee = 1'b0; elig = 4'b0;
    if (rst_d) begin
      for (int o = 0; o < 4; o++) begin
        m_locked[o] = 1'b0; m_owner[o] = 0; m_ptr[o] = 0; m_sel[o] = 0;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        logic [3:0] s;
        s = rq_d[i*4 +: 4];
        dst[i] = -1;
        for (int b = 0; b < 4; b++) if (s[b]) dst[i] = b;
        if (v_d[i] && $countones(s) != 1) ee = 1'b1;
        elig[i] = v_d[i] && ($countones(s) == 1) && !m_grant[i];
      end
      for (int o = 0; o < 4; o++) begin
        win = -1;
        if (rdy_d[o]) begin
          if (m_locked[o]) begin
            if (elig[m_owner[o]] && dst[m_owner[o]] == o) win = m_owner[o];
          end else begin
            for (int k = 0; k < 4; k++) begin
              int c;
              c = (m_ptr[o] + k) % 4;
              if (win < 0 && elig[c] && dst[c] == o) win = c;
            end
          end
        end
        if (win >= 0) begin
          eg[win] = 1'b1; ev[o] = 1'b1; m_sel[o] = win;
          if (!m_locked[o]) begin
            m_ptr[o] = (win + 1) % 4; m_owner[o] = win; m_locked[o] = !tl_d[win];
          end else if (tl_d[win]) begin
            m_locked[o] = 1'b0;
          end
        end
      end
    end
    m_grant = eg;
    for (int o = 0; o < 4; o++) es[o*2 +: 2] = 2'(m_sel[o]);
    @(posedge clk);
    #1;
    chk("sw_grant", 32'(sw_grant), 32'(eg));
    chk("xbar_valid", 32'(xbar_valid), 32'(ev));
    chk("xbar_sel", 32'(xbar_sel), 32'(es));
    chk("req_err", 32'(req_err), 32'(ee));
    for (int i = 0; i < 4; i++)
      if (fh[i] != ft[i] && (eg[i] || fbuf[i][fh[i] % 256].bad)) fh[i]++;
    drive();
  endtask

  task automatic drain();
    for (int k = 0; k < 40; k++) begin
      if (fh[0] == ft[0] && fh[1] == ft[1] && fh[2] == ft[2] && fh[3] == ft[3]) break;
      step();
    end
    step();
  endtask

  int order [6] = '{0, 1, 3, 0, 1, 3};
  int got [$];

  initial begin
    for (int i = 0; i < 4; i++) begin fh[i] = 0; ft[i] = 0; end
    m_grant = 4'b0;
    rst_d = 1'b1; rdy_d = 4'b1111;
    drive();
    step(); step();
    chk("reset_grant", 32'(sw_grant), 32'h0);
    rst_d = 1'b0;

    // 1: single-flit packet from input 2 to output 0
    push_pkt(2, 0, 1); drive();
    step();
    chk("t1_grant", 32'(sw_grant), 32'h4);
    chk("t1_sel0", 32'(xbar_sel[1:0]), 32'd2);
    chk("t1_valid0", 32'(xbar_valid[0]), 32'd1);
    step();
    chk("t1_pulse", 32'(sw_grant), 32'h0);

    // 2: round-robin on output 1 among inputs 0, 1, 3
    for (int k = 0; k < 2; k++) begin push_pkt(0, 1, 1); push_pkt(1, 1, 1); push_pkt(3, 1, 1); end
    drive();
    for (int k = 0; k < 6; k++) begin
      step();
      chk("t2_order", 32'(sw_grant), 32'(1 << order[k]));
      chk("t2_sel1", 32'(xbar_sel[3:2]), 32'(order[k]));
    end
    drain();

    // 3: input 1 holds output 2 for a 3-flit packet while input 0 waits
    push_pkt(1, 2, 3); drive();
    step();
    if (xbar_valid[2]) got.push_back(int'(xbar_sel[5:4]));
    push_pkt(0, 2, 1); drive();
    for (int k = 0; k < 8; k++) begin
      step();
      if (xbar_valid[2]) got.push_back(int'(xbar_sel[5:4]));
    end
    chk("t3_count", 32'(got.size()), 32'd4);
    for (int k = 0; k < 4; k++) chk("t3_owner", (k < got.size()) ? 32'(got[k]) : 32'hffff, (k < 3) ? 32'd1 : 32'd0);
    drain();

    // 4: backpressure on output 3 mid-packet from input 2
    push_pkt(2, 3, 4); drive();
    step();
    chk("t4_head", 32'(sw_grant), 32'h4);
    rdy_d = 4'b0111;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("t4_stall_grant", 32'(sw_grant), 32'h0);
      chk("t4_stall_valid", 32'(xbar_valid[3]), 32'd0);
    end
    rdy_d = 4'b1111;
    step();
    chk("t4_resume", 32'(sw_grant), 32'h4);
    chk("t4_sel3", 32'(xbar_sel[7:6]), 32'd2);
    drain();

    // 5: malformed request alongside two independent grants
    push(0, 4'b0110, 1'b1, 1'b1); push_pkt(1, 0, 1); push_pkt(2, 3, 1); drive();
    step();
    chk("t5_err", 32'(req_err), 32'd1);
    chk("t5_grant", 32'(sw_grant), 32'h6);
    chk("t5_valid", 32'(xbar_valid), 32'h9);
    drain();

    // 6: reset while output 2 is locked by input 1
    push_pkt(1, 2, 3); drive();
    step(); step();
    rst_d = 1'b1;
    step();
    chk("t6_rst_grant", 32'(sw_grant), 32'h0);
    chk("t6_rst_valid", 32'(xbar_valid), 32'h0);
    chk("t6_rst_sel", 32'(xbar_sel), 32'h0);
    rst_d = 1'b0;
    for (int i = 0; i < 4; i++) fh[i] = ft[i];
    push_pkt(3, 2, 1); drive();
    step();
    chk("t6_new_head", 32'(sw_grant), 32'h8);
    chk("t6_sel2", 32'(xbar_sel[5:4]), 32'd3);
    drain();

    // Random traffic against the model
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < 4; i++) begin
        if (fh[i] == ft[i] && $urandom_range(0, 3) == 0) begin
          if ($urandom_range(0, 15) == 0) begin
            logic [15:0] badv;
            badv = 16'h0_3_A_F;
            push(i, badv[$urandom_range(0, 3)*4 +: 4], 1'b1, 1'b1);
          end else begin
            push_pkt(i, $urandom_range(0, 3), $urandom_range(1, 3));
          end
        end
      end
      for (int o = 0; o < 4; o++) rdy_d[o] = ($urandom_range(0, 3) != 0);
      drive();
      step();
    end

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
